// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared valid/ready memory, with sticky illegal-op flag and retire counter.
module mips_mc_controller #(
  parameter bit          ENABLE_BNE  = 1'b1,
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [5:0]       op_i6,
  input  logic [5:0]       funct_i6,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o2,
  output logic [2:0]       alu_ctrl_o3,
  output logic [1:0]       pc_src_o2,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [3:0]       state_o4
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, state_nxt;
  logic   retire_c;
  logic   trap_c;

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= S_FETCH;
    else           state <= state_nxt;
  end

  // Next state and control decode
  always_comb begin
    state_nxt    = state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o2 = 2'b00;
    alu_ctrl_o3  = ALU_ADD;
    pc_src_o2    = 2'b00;
    retire_c     = 1'b0;
    trap_c       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o2 = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b_o2 = 2'b11;
        case (op_i6)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_BNE:       state_nxt = ENABLE_BNE ? S_BRANCH : S_TRAP;
          OP_ADDI:      state_nxt = ENABLE_ADDI ? S_ADDIEX : S_TRAP;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_nxt    = (op_i6 == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire_c     = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        state_nxt   = S_ALUWB;
        case (funct_i6)
          6'b100000: alu_ctrl_o3 = ALU_ADD;
          6'b100010: alu_ctrl_o3 = ALU_SUB;
          6'b100100: alu_ctrl_o3 = ALU_AND;
          6'b100101: alu_ctrl_o3 = ALU_OR;
          6'b101010: alu_ctrl_o3 = ALU_SLT;
          default:   state_nxt   = S_TRAP;
        endcase
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire_c    = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o3 = ALU_SUB;
        pc_src_o2   = 2'b01;
        // bne only reaches here when enabled, so op alone picks the polarity
        pc_write_o  = (op_i6 == OP_BNE) ? ~zero_i : zero_i;
        retire_c    = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o2 = 2'b10;
        state_nxt    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_o = 1'b1;
        retire_c    = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o2  = 2'b10;
        pc_write_o = 1'b1;
        retire_c   = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_TRAP: begin
        trap_c    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Write enables are suppressed for as long as reset is held
    if (!reset_ni) begin
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      mem_we_o    = 1'b0;
    end
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      illegal_o     <= 1'b0;
      retired_cnt_o <= '0;
    end else begin
      if (trap_c)   illegal_o     <= 1'b1;
      if (retire_c) retired_cnt_o <= retired_cnt_o + CNT_W'(1);
    end
  end

  assign state_o4 = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomised bench for mips_mc_controller: two instances (full-featured, and
// bne/addi disabled with a 2-bit counter) checked every cycle against a phase-list model.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_ni;
  logic [1:0][5:0] op, funct;
  logic [1:0]      zero, ready;
  logic [1:0]      mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0]      reg_dst, mem_to_reg, src_a, illegal;
  logic [1:0][1:0] src_b, pc_src;
  logic [1:0][2:0] alu;
  logic [1:0][3:0] state;
  logic [31:0]     cnt0;
  logic [1:0]      cnt1;

  mips_mc_controller u0 (
    .clk_i(clk), .reset_ni(reset_ni), .op_i6(op[0]), .funct_i6(funct[0]),
    .zero_i(zero[0]), .mem_ready_i(ready[0]), .mem_req_o(mem_req[0]),
    .mem_we_o(mem_we[0]), .iord_o(iord[0]), .ir_write_o(ir_write[0]),
    .pc_write_o(pc_write[0]), .reg_write_o(reg_write[0]), .reg_dst_o(reg_dst[0]),
    .mem_to_reg_o(mem_to_reg[0]), .alu_src_a_o(src_a[0]), .alu_src_b_o2(src_b[0]),
    .alu_ctrl_o3(alu[0]), .pc_src_o2(pc_src[0]), .illegal_o(illegal[0]),
    .retired_cnt_o(cnt0), .state_o4(state[0])
  );

  mips_mc_controller #(.ENABLE_BNE(1'b0), .ENABLE_ADDI(1'b0), .CNT_W(2)) u1 (
    .clk_i(clk), .reset_ni(reset_ni), .op_i6(op[1]), .funct_i6(funct[1]),
    .zero_i(zero[1]), .mem_ready_i(ready[1]), .mem_req_o(mem_req[1]),
    .mem_we_o(mem_we[1]), .iord_o(iord[1]), .ir_write_o(ir_write[1]),
    .pc_write_o(pc_write[1]), .reg_write_o(reg_write[1]), .reg_dst_o(reg_dst[1]),
    .mem_to_reg_o(mem_to_reg[1]), .alu_src_a_o(src_a[1]), .alu_src_b_o2(src_b[1]),
    .alu_ctrl_o3(alu[1]), .pc_src_o2(pc_src[1]), .illegal_o(illegal[1]),
    .retired_cnt_o(cnt1), .state_o4(state[1])
  );

  int checks = 0, errors = 0;

  // Model: per instance, the list of phases the current instruction walks through
  int         ph[2][8];
  int         plen[2], ppos[2];
  bit         is_bne[2], retires[2], exp_ill[2];
  logic [5:0] cur_funct[2];
  longint     exp_cnt[2];

  int force_kind  = -1;
  int ready_force = -1;
  bit hold_wr     = 1'b0;
  bit scr_on      = 1'b0;
  int scr_pos     = 0;
  bit scr[10];

  function automatic logic [63:0] cnt_of(input int k);
    return (k == 0) ? 64'(cnt0) : 64'(cnt1);
  endfunction

  function automatic longint cmod(input int k);
    return (k == 0) ? 64'd4294967296 : 64'd4;
  endfunction

  function automatic bit legal_funct(input logic [5:0] f);
    return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d required=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int p);
    ph[k][plen[k]] = p;
    plen[k]++;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      plen[k] = 0; ppos[k] = 0; exp_cnt[k] = 0; exp_ill[k] = 1'b0;
    end
  endtask

  // Pick an instruction and lay out its phases from the ISA rules
  task automatic start_instr(input int k);
    int         kind;
    logic [5:0] o, f;
    kind = (force_kind >= 0) ? force_kind : int'($urandom_range(0, 8));
    f = 6'($urandom);
    o = 6'h00;
    plen[k] = 0; ppos[k] = 0; retires[k] = 1'b1; is_bne[k] = 1'b0;
    push(k, 0); push(k, 1);
    case (kind)
      0: begin o = 6'h23; push(k, 2); push(k, 3); push(k, 4); end
      1: begin o = 6'h2B; push(k, 2); push(k, 5); end
      2: begin
        case ($urandom_range(0, 4))
          0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; default: f = 6'h2A;
        endcase
        push(k, 6); push(k, 7);
      end
      3: begin
        while (legal_funct(f)) f = 6'($urandom);
        push(k, 6); push(k, 12); retires[k] = 1'b0;
      end
      4: begin o = 6'h04; push(k, 8); end
      5: begin
        o = 6'h05; is_bne[k] = 1'b1;
        if (k == 0) push(k, 8);
        else begin push(k, 12); retires[k] = 1'b0; end
      end
      6: begin
        o = 6'h08;
        if (k == 0) begin push(k, 9); push(k, 10); end
        else begin push(k, 12); retires[k] = 1'b0; end
      end
      7: begin o = 6'h02; push(k, 11); end
      default: begin
        o = 6'($urandom);
        while (o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02}) o = 6'($urandom);
        push(k, 12); retires[k] = 1'b0;
      end
    endcase
    op[k] = o; funct[k] = f; cur_funct[k] = f;
  endtask

  task automatic compare(input int k);
    int p;
    bit pcw;
    p   = ph[k][ppos[k]];
    pcw = (p == 0 && ready[k]) || p == 11 || (p == 8 && (is_bne[k] ? !zero[k] : zero[k]));
    chk("state", k, 64'(state[k]), 64'(p));
    chk("mem_req", k, 64'(mem_req[k]), 64'(p == 0 || p == 3 || p == 5));
    chk("mem_we", k, 64'(mem_we[k]), 64'(p == 5));
    chk("ir_write", k, 64'(ir_write[k]), 64'(p == 0 && ready[k]));
    chk("pc_write", k, 64'(pc_write[k]), 64'(pcw));
    chk("reg_write", k, 64'(reg_write[k]), 64'(p == 4 || p == 7 || p == 10));
    chk("retired_cnt", k, cnt_of(k), 64'(exp_cnt[k]));
    chk("illegal", k, 64'(illegal[k]), 64'(exp_ill[k]));
    if (p inside {0, 3, 5}) chk("iord", k, 64'(iord[k]), 64'(p != 0));
    if (p inside {4, 7, 10}) begin
      chk("reg_dst", k, 64'(reg_dst[k]), 64'(p == 7));
      chk("mem_to_reg", k, 64'(mem_to_reg[k]), 64'(p == 4));
    end
    if (p inside {0, 1, 2, 6, 8, 9}) begin
      chk("alu_src_a", k, 64'(src_a[k]), 64'(p >= 2));
      chk("alu_src_b", k, 64'(src_b[k]),
          64'((p == 0) ? 1 : (p == 1) ? 3 : (p == 2 || p == 9) ? 2 : 0));
    end
    if (p inside {0, 1, 2, 9}) chk("alu_ctrl", k, 64'(alu[k]), 64'd2);
    if (p == 8) chk("alu_ctrl", k, 64'(alu[k]), 64'd6);
    if (p == 6 && legal_funct(cur_funct[k])) chk("alu_ctrl", k, 64'(alu[k]), 64'(alu_of(cur_funct[k])));
    if (p inside {0, 8, 11}) chk("pc_src", k, 64'(pc_src[k]), 64'((p == 0) ? 0 : (p == 8) ? 1 : 2));
  endtask

  task automatic advance(input int k);
    int p;
    p = ph[k][ppos[k]];
    if (p inside {0, 3, 5} && !ready[k]) return;
    ppos[k]++;
    if (ppos[k] == plen[k]) begin
      if (retires[k]) exp_cnt[k] = (exp_cnt[k] + 1) % cmod(k);
      if (p == 12) exp_ill[k] = 1'b1;
    end
  endtask

  // One clock: drive at negedge, check 1 ns later, then step the model
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ppos[k] >= plen[k]) start_instr(k);
      zero[k] = 1'($urandom_range(0, 1));
      if (scr_on) ready[k] = scr[scr_pos];
      else if (ready_force >= 0) ready[k] = 1'(ready_force);
      else ready[k] = ($urandom_range(0, 3) != 0);
      if (hold_wr && ph[k][ppos[k]] == 5) ready[k] = 1'b0;
    end
    if (scr_on && scr_pos < 9) scr_pos++;
    #1;
    for (int k = 0; k < 2; k++) begin
      compare(k);
      advance(k);
    end
  endtask

  task automatic chk_quiet(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_state"}, k, 64'(state[k]), 64'd0);
      chk({nm, "_ir_write"}, k, 64'(ir_write[k]), 64'd0);
      chk({nm, "_pc_write"}, k, 64'(pc_write[k]), 64'd0);
      chk({nm, "_reg_write"}, k, 64'(reg_write[k]), 64'd0);
      chk({nm, "_mem_we"}, k, 64'(mem_we[k]), 64'd0);
      chk({nm, "_cnt"}, k, cnt_of(k), 64'd0);
      chk({nm, "_illegal"}, k, 64'(illegal[k]), 64'd0);
    end
  endtask

  initial begin
    int st[4];
    int irw;
    int guard;
    reset_ni = 1'b0;
    op = '0; funct = '0; zero = '0; ready = 2'b11;
    model_reset();
    scr[0] = 0; scr[1] = 0; scr[2] = 0; scr[3] = 1; scr[4] = 1;
    scr[5] = 1; scr[6] = 0; scr[7] = 0; scr[8] = 1; scr[9] = 1;

    // Reset held with ready high: FETCH, but no IR/PC write
    @(negedge clk); #1;
    chk_quiet("reset");
    ready = 2'b00;
    reset_ni = 1'b1;

    // add: FETCH, DECODE, EXEC, ALUWB
    force_kind = 2; ready_force = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      st[i] = int'(state[0]);
    end
    chk("add_trace0", 0, 64'(st[0]), 64'd0);
    chk("add_trace1", 0, 64'(st[1]), 64'd1);
    chk("add_trace2", 0, 64'(st[2]), 64'd6);
    chk("add_trace3", 0, 64'(st[3]), 64'd7);
    @(posedge clk); #1;
    chk("add_cnt", 0, cnt_of(0), 64'd1);
    chk("add_cnt", 1, cnt_of(1), 64'd1);

    // bne: branches on inst0, traps on inst1 without retiring
    force_kind = 5;
    repeat (3) cycle();
    @(posedge clk); #1;
    chk("bne_illegal", 0, 64'(illegal[0]), 64'd0);
    chk("bne_illegal", 1, 64'(illegal[1]), 64'd1);
    chk("bne_cnt", 0, cnt_of(0), 64'd2);
    chk("bne_cnt", 1, cnt_of(1), 64'd1);

    // Four jumps: 2-bit counter goes 1 -> 5 mod 4 = 1
    force_kind = 7;
    repeat (12) cycle();
    @(posedge clk); #1;
    chk("wrap_cnt", 0, cnt_of(0), 64'd6);
    chk("wrap_cnt", 1, cnt_of(1), 64'd1);
    chk("sticky_illegal", 1, 64'(illegal[1]), 64'd1);

    // lw with 3 FETCH stalls and 2 MEMRD stalls
    force_kind = 0; ready_force = -1; scr_on = 1'b1; scr_pos = 0; irw = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      irw += int'(ir_write[0]);
    end
    scr_on = 1'b0;
    @(posedge clk); #1;
    chk("lw_ir_writes", 0, 64'(irw), 64'd1);
    chk("lw_state", 0, 64'(state[0]), 64'd0);
    chk("lw_cnt", 0, cnt_of(0), 64'd7);

    // Random instruction mix and memory latency
    force_kind = -1;
    repeat (3000) cycle();

    // Abort a stalled sw with an asynchronous reset
    force_kind = 1; hold_wr = 1'b1; guard = 0;
    while (!(ph[0][ppos[0]] == 5 && ph[1][ppos[1]] == 5 && ppos[0] < plen[0] && ppos[1] < plen[1])
           && guard < 300) begin
      cycle();
      guard++;
    end
    chk("reach_memwr", 0, 64'(guard < 300), 64'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk_quiet("async_reset");
    model_reset();
    hold_wr = 1'b0; force_kind = -1;
    @(negedge clk);
    ready = 2'b00;
    reset_ni = 1'b1;
    repeat (500) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
